pattern_seq_gen: RTL and testbench
==================================

PATTERN_SEQ_GEN -- requirements
Module: pattern_seq_gen

Interface
REQ-001 Parameter PAT_W, default 4, pattern length in bits (legal range 2..16).
REQ-002 Parameter CNT_W, default 4, width of the repetition count.
REQ-003 clk  input  1  single clock; all state changes on the rising edge.
REQ-004 reset  input  1  synchronous, active-low reset (reset=0 at a rising edge resets the block).
REQ-005 start  input  1  request to begin a transmission; sampled only in IDLE.
REQ-006 pattern  input  PAT_W  bit pattern to send, MSB first; captured with start.
REQ-007 repeat_cnt  input  CNT_W  number of pattern repetitions; captured with start.
REQ-008 overlap  input  1  overlapping-repetition mode; captured with start.
REQ-009 stop  input  1  graceful stop request, honoured at the end of the current repetition.
REQ-010 out  output  1  serial data bit, registered.
REQ-011 out_valid  output  1  high in every cycle where out carries a pattern bit.
REQ-012 busy  output  1  high from the cycle after start acceptance until the done cycle, inclusive.
REQ-013 done  output  1  single-cycle pulse marking the end of a transmission.

Function
REQ-014 The FSM SHALL have states IDLE, SEND and FIN, and reset SHALL place it in IDLE.
REQ-015 In IDLE with start=1, the block SHALL capture pattern, repeat_cnt and overlap, then move to SEND, or to FIN if repeat_cnt=0.
REQ-016 The first bit, pattern[PAT_W-1], SHALL appear on out with out_valid=1 in the cycle after start is accepted (latency 1).
REQ-017 SEND SHALL emit exactly one bit per cycle, MSB to LSB, with no gaps while out_valid=1.
REQ-018 Non-overlap mode SHALL emit repeat_cnt*PAT_W bits, each repetition beginning again at the MSB.
REQ-019 Overlap mode SHALL emit PAT_W bits for the first repetition and PAT_W-1 bits (pattern[PAT_W-2:0]) for each later repetition.
REQ-020 Overlap mode SHALL apply only when the captured pattern[PAT_W-1]==pattern[0]; otherwise the block SHALL use non-overlap mode.
REQ-021 stop=1 during SEND SHALL be latched, and transmission SHALL end after the last bit of the current repetition.
REQ-022 stop asserted in the final bit cycle of a repetition SHALL end the transmission after that bit.
REQ-023 After the last bit, the block SHALL enter FIN for exactly one cycle with done=1, out_valid=0 and out=0, then return to IDLE.
REQ-024 start SHALL be ignored in SEND and FIN.
REQ-025 start asserted in the FIN cycle SHALL NOT be accepted.
REQ-026 Changes on pattern, repeat_cnt or overlap after capture SHALL have no effect on the transmission in progress.
REQ-027 The repetition counter SHALL be CNT_W bits wide and SHALL never wrap: the maximum count 2^CNT_W-1 SHALL be sent completely.
REQ-028 out SHALL be 0 whenever out_valid=0.

Reset
REQ-029 On reset=0, the outputs SHALL take out=0, out_valid=0, busy=0, done=0 at the next rising edge.
REQ-030 On reset=0, all internal counters, the shift register and the stop latch SHALL clear at the next rising edge.
REQ-031 Reset asserted mid-transmission SHALL abort the transmission immediately, with no done pulse.
REQ-032 Reset SHALL take priority over start and stop.

Structure
REQ-033 A shared package pattern_pkg SHALL hold the state encoding (IDLE, SEND, FIN) and the default PAT_W and CNT_W constants.
REQ-034 The PAT_W-bit parallel-load, MSB-first shift register with reload-from-captured-pattern SHALL be the sub-module pattern_shifter.
REQ-035 The FSM, repetition counter and bit counter SHALL remain in pattern_seq_gen.

Verification
REQ-036 Scenario: pattern=4'b1001, repeat_cnt=1, overlap=0, start for 1 cycle -> out=1,0,0,1 on 4 consecutive valid cycles starting 1 cycle after start, then done for 1 cycle.
REQ-037 Scenario: pattern=4'b1001, repeat_cnt=2, overlap=1 -> 7 valid bits 1001001, then done.
REQ-038 Scenario: pattern=4'b1001, repeat_cnt=2, overlap=0 -> 8 bits 10011001, then done.
REQ-039 Scenario: pattern=4'b1100, repeat_cnt=3, overlap=1 -> the first bit differs from the last, so 12 bits 110011001100 are sent.
REQ-040 Scenario: repeat_cnt=0 -> no valid bits, done one cycle after start, busy high for that one cycle only.
REQ-041 Scenario: repeat_cnt=5, stop pulsed on the 2nd bit of the 2nd repetition -> 8 bits sent, then done.
REQ-042 Scenario: reset=0 during the 3rd bit -> out_valid=0 and busy=0 at the next edge, no done pulse, and a new start is accepted after reset=1.

Source files
------------

// File: rtl/pattern_pkg.sv
// Shared types and defaults for the serial pattern sequence generator.
// Holds the FSM state encoding and the shifter operation codes.
package pattern_pkg;

    localparam int PAT_W_DEF = 4;
    localparam int CNT_W_DEF = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        FIN  = 2'd2
    } state_t;

    typedef enum logic [2:0] {
        SH_HOLD       = 3'd0,
        SH_LOAD       = 3'd1,
        SH_SHIFT      = 3'd2,
        SH_RELOAD     = 3'd3,
        SH_RELOAD_OVL = 3'd4
    } sh_op_t;

endpackage

// File: rtl/pattern_seq_gen_if.sv
// Request/response bundle between a controller and the pattern generator.
// Clock and reset stay outside so the block keeps plain scalar clk/reset ports.
interface pattern_seq_gen_if #(
    parameter int PAT_W = 4,
    parameter int CNT_W = 4
);
    logic             start;
    logic [PAT_W-1:0] pattern;
    logic [CNT_W-1:0] repeat_cnt;
    logic             overlap;
    logic             stop;
    logic             out;
    logic             out_valid;
    logic             busy;
    logic             done;

    modport master (
        output start, pattern, repeat_cnt, overlap, stop,
        input  out, out_valid, busy, done
    );

    modport slave (
        input  start, pattern, repeat_cnt, overlap, stop,
        output out, out_valid, busy, done
    );

endinterface

// File: rtl/pattern_shifter.sv
// MSB-first shift register holding the bits still to be sent in the current
// repetition, plus the captured pattern used to restart each repetition.
module pattern_shifter
    import pattern_pkg::*;
#(
    parameter int PAT_W = PAT_W_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  sh_op_t           op_i,
    input  logic [PAT_W-1:0] pattern_i,
    output logic             msb_o,
    output logic             first_full_o,
    output logic             first_ovl_o
);

    logic [PAT_W-1:0] cap_q;
    logic [PAT_W-1:0] sh_q;

    // The bit currently on the output is already consumed, so each load
    // leaves the following bit in the MSB position.
    always_ff @(posedge clk) begin
        if (!reset) begin
            cap_q <= '0;
            sh_q  <= '0;
        end else begin
            case (op_i)
                SH_LOAD: begin
                    cap_q <= pattern_i;
                    sh_q  <= pattern_i << 1;
                end
                SH_SHIFT:      sh_q <= sh_q << 1;
                SH_RELOAD:     sh_q <= cap_q << 1;
                SH_RELOAD_OVL: sh_q <= cap_q << 2;
                default: begin
                    cap_q <= cap_q;
                    sh_q  <= sh_q;
                end
            endcase
        end
    end

    assign msb_o        = sh_q[PAT_W-1];
    assign first_full_o = cap_q[PAT_W-1];
    assign first_ovl_o  = cap_q[PAT_W-2];

endmodule

// File: rtl/pattern_seq_gen.sv
// Serial pattern generator: sends a captured pattern MSB first a given number
// of times, optionally sharing the end/start bit between repetitions.
module pattern_seq_gen
    import pattern_pkg::*;
#(
    parameter int PAT_W = PAT_W_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    pattern_seq_gen_if.slave  bus
);

    localparam int BIT_W = $clog2(PAT_W);
    localparam logic [BIT_W-1:0] LAST_FULL = BIT_W'(PAT_W - 1);
    localparam logic [BIT_W-1:0] LAST_OVL  = BIT_W'(PAT_W - 2);

    state_t           state_q;
    logic             out_q;
    logic             out_valid_q;
    logic             busy_q;
    logic             done_q;
    logic [BIT_W-1:0] bit_q;
    logic [CNT_W-1:0] rep_q;
    logic             first_q;
    logic             ovl_q;
    logic             stop_q;

    sh_op_t           sh_op_d;
    logic             sh_msb;
    logic             first_full;
    logic             first_ovl;
    logic [BIT_W-1:0] last_idx_d;
    logic             last_bit_d;
    logic             end_tx_d;
    logic             next_rep_bit_d;

    pattern_shifter #(
        .PAT_W (PAT_W)
    ) u_shifter (
        .clk          (clk),
        .reset        (reset),
        .op_i         (sh_op_d),
        .pattern_i    (bus.pattern),
        .msb_o        (sh_msb),
        .first_full_o (first_full),
        .first_ovl_o  (first_ovl)
    );

    // Later overlapped repetitions skip the shared MSB and so are one bit shorter.
    always_comb begin
        last_idx_d     = (ovl_q && !first_q) ? LAST_OVL : LAST_FULL;
        last_bit_d     = (bit_q == last_idx_d);
        end_tx_d       = last_bit_d && ((rep_q == CNT_W'(1)) || stop_q || bus.stop);
        next_rep_bit_d = ovl_q ? first_ovl : first_full;
        sh_op_d        = SH_HOLD;
        case (state_q)
            IDLE: if (bus.start) sh_op_d = SH_LOAD;
            SEND: begin
                if (!last_bit_d)    sh_op_d = SH_SHIFT;
                else if (!end_tx_d) sh_op_d = ovl_q ? SH_RELOAD_OVL : SH_RELOAD;
            end
            default: sh_op_d = SH_HOLD;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= IDLE;
            out_q       <= 1'b0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            bit_q       <= '0;
            rep_q       <= '0;
            first_q     <= 1'b0;
            ovl_q       <= 1'b0;
            stop_q      <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        ovl_q   <= bus.overlap && (bus.pattern[PAT_W-1] == bus.pattern[0]);
                        rep_q   <= bus.repeat_cnt;
                        bit_q   <= '0;
                        first_q <= 1'b1;
                        stop_q  <= 1'b0;
                        busy_q  <= 1'b1;
                        if (bus.repeat_cnt == '0) begin
                            state_q     <= FIN;
                            done_q      <= 1'b1;
                            out_q       <= 1'b0;
                            out_valid_q <= 1'b0;
                        end else begin
                            state_q     <= SEND;
                            out_q       <= bus.pattern[PAT_W-1];
                            out_valid_q <= 1'b1;
                        end
                    end
                end
                SEND: begin
                    if (bus.stop) stop_q <= 1'b1;
                    if (!last_bit_d) begin
                        bit_q <= bit_q + 1'b1;
                        out_q <= sh_msb;
                    end else if (end_tx_d) begin
                        state_q     <= FIN;
                        out_q       <= 1'b0;
                        out_valid_q <= 1'b0;
                        done_q      <= 1'b1;
                        stop_q      <= 1'b0;
                    end else begin
                        bit_q   <= '0;
                        first_q <= 1'b0;
                        rep_q   <= rep_q - 1'b1;
                        out_q   <= next_rep_bit_d;
                    end
                end
                FIN: begin
                    state_q <= IDLE;
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.out       = out_q;
    assign bus.out_valid = out_valid_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;

endmodule

// File: tb/tb_pattern_seq_gen.sv
// Directed bench for pattern_seq_gen: hand-computed bit streams, stop, reset
// abort, zero and maximum repetition counts.
module tb_pattern_seq_gen;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    pattern_seq_gen_if #(.PAT_W(4), .CNT_W(4)) bus ();

    pattern_seq_gen #(.PAT_W(4), .CNT_W(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic e_out, input logic e_vld,
                         input logic e_busy, input logic e_done);
        checks += 4;
        assert (bus.out === e_out) else begin
            errors++;
            $error("FAIL %s out: observed %b expected %b", tag, bus.out, e_out);
        end
        assert (bus.out_valid === e_vld) else begin
            errors++;
            $error("FAIL %s out_valid: observed %b expected %b", tag, bus.out_valid, e_vld);
        end
        assert (bus.busy === e_busy) else begin
            errors++;
            $error("FAIL %s busy: observed %b expected %b", tag, bus.busy, e_busy);
        end
        assert (bus.done === e_done) else begin
            errors++;
            $error("FAIL %s done: observed %b expected %b", tag, bus.done, e_done);
        end
    endtask

    // Start a transmission, scramble the inputs after capture, then expect
    // n valid bits (exp[n-1] first), one done cycle and a return to idle.
    // start is raised in the done cycle to show it is not accepted there.
    task automatic run_tx(input string tag, input logic [3:0] pat, input logic [3:0] cnt,
                          input logic ovl, input logic hold_start, input int stop_at,
                          input logic [63:0] exp_bits, input int n);
        bus.pattern    = pat;
        bus.repeat_cnt = cnt;
        bus.overlap    = ovl;
        bus.start      = 1'b1;
        tick();
        bus.start      = hold_start;
        bus.pattern    = ~pat;
        bus.repeat_cnt = 4'hF;
        bus.overlap    = ~ovl;
        for (int i = 0; i < n; i++) begin
            check($sformatf("%s bit%0d", tag, i), exp_bits[n-1-i], 1'b1, 1'b1, 1'b0);
            bus.stop = (i == stop_at);
            tick();
        end
        bus.stop = 1'b0;
        check($sformatf("%s fin", tag), 1'b0, 1'b0, 1'b1, 1'b1);
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        check($sformatf("%s idle", tag), 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        reset          = 1'b0;
        bus.start      = 1'b1;
        bus.pattern    = 4'b1001;
        bus.repeat_cnt = 4'd1;
        bus.overlap    = 1'b0;
        bus.stop       = 1'b1;
        tick();
        tick();
        check("reset", 1'b0, 1'b0, 1'b0, 1'b0);
        bus.start = 1'b0;
        bus.stop  = 1'b0;
        reset     = 1'b1;
        tick();
        check("post_reset_idle", 1'b0, 1'b0, 1'b0, 1'b0);

        run_tx("single",      4'b1001, 4'd1,  1'b0, 1'b0, -1, 64'b1001, 4);
        run_tx("ovl2",        4'b1001, 4'd2,  1'b1, 1'b0, -1, 64'b1001001, 7);
        run_tx("novl2_hold",  4'b1001, 4'd2,  1'b0, 1'b1, -1, 64'b10011001, 8);
        run_tx("ovl_mismatch",4'b1100, 4'd3,  1'b1, 1'b0, -1, 64'b110011001100, 12);
        run_tx("ovl3_0110",   4'b0110, 4'd3,  1'b1, 1'b0, -1, 64'b0110110110, 10);
        run_tx("zero_cnt",    4'b1001, 4'd0,  1'b0, 1'b0, -1, 64'd0, 0);
        run_tx("stop_rep2",   4'b1001, 4'd5,  1'b0, 1'b0, 5,  64'b10011001, 8);
        run_tx("stop_last",   4'b1011, 4'd3,  1'b0, 1'b0, 3,  64'b1011, 4);
        run_tx("max_cnt",     4'b1010, 4'd15, 1'b0, 1'b0, -1, 64'h0AAA_AAAA_AAAA_AAAA, 60);

        // Abort with reset while the third bit is on the output.
        bus.pattern    = 4'b1001;
        bus.repeat_cnt = 4'd2;
        bus.overlap    = 1'b0;
        bus.start      = 1'b1;
        tick();
        bus.start = 1'b0;
        check("abort bit0", 1'b1, 1'b1, 1'b1, 1'b0);
        tick();
        check("abort bit1", 1'b0, 1'b0 | 1'b1, 1'b1, 1'b0);
        tick();
        check("abort bit2", 1'b0, 1'b1, 1'b1, 1'b0);
        reset     = 1'b0;
        bus.start = 1'b1;
        tick();
        check("abort reset", 1'b0, 1'b0, 1'b0, 1'b0);
        reset     = 1'b1;
        bus.start = 1'b0;
        tick();
        check("abort no_done", 1'b0, 1'b0, 1'b0, 1'b0);
        run_tx("after_abort", 4'b1110, 4'd1, 1'b0, 1'b0, -1, 64'b1110, 4);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
